// File: rtl/instr_mem_param_if.sv
// Fetch/load bus between the instruction memory and its consumer.
// master = fetch unit / program loader, slave = memory.
interface instr_mem_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              stall;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic              addr_err;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              busy;

  modport master (
    output fetch_req,
    output fetch_addr,
    output stall,
    output load_en,
    output load_addr,
    output load_data,
    input  fetch_ready,
    input  instr_out,
    input  instr_valid,
    input  addr_err,
    input  busy
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    input  stall,
    input  load_en,
    input  load_addr,
    input  load_data,
    output fetch_ready,
    output instr_out,
    output instr_valid,
    output addr_err,
    output busy
  );
endinterface

// File: rtl/instr_mem_param.sv
// Parameterised instruction memory: NOP-clearing init sweep,
// 1-cycle registered fetch with stall hold, and a program-load port.
module instr_mem_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 32,
  parameter int BYTE_ADDR = 0
) (
  input logic clk,
  input logic rst,
  instr_mem_param_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IDX_W-1:0]  clr_cnt;
  logic [IDX_W-1:0]  clr_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] out_q;
  logic              valid_q;
  logic              err_q;
  logic              run;
  logic              ready;

  logic [ADDR_W-1:0] f_word;
  logic [ADDR_W-1:0] l_word;
  logic              f_mis;
  logic              l_mis;
  logic              f_bad;
  logic              l_bad;
  logic [IDX_W-1:0]  f_idx;
  logic [IDX_W-1:0]  l_idx;

  // Range check uses the whole word address so high bits never alias.
  always_comb begin
    f_word = bus.fetch_addr;
    l_word = bus.load_addr;
    f_mis  = 1'b0;
    l_mis  = 1'b0;
    if (BYTE_ADDR != 0) begin
      f_word = bus.fetch_addr >> 2;
      l_word = bus.load_addr >> 2;
      f_mis  = bus.fetch_addr[1:0] != 2'b00;
      l_mis  = bus.load_addr[1:0] != 2'b00;
    end
    f_bad = f_mis || (f_word >= DEPTH_A);
    l_bad = l_mis || (l_word >= DEPTH_A);
    f_idx = f_word[IDX_W-1:0];
    l_idx = l_word[IDX_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    unique case (state)
      INIT: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST) begin
          state_nxt   = RUN;
          clr_cnt_nxt = '0;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign run   = (state == RUN);
  assign ready = run && !(valid_q && bus.stall);

  // Nonblocking write gives read-before-write on a same-index collision.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_cnt] <= '0;
    end else if (bus.load_en && !l_bad) begin
      mem[l_idx] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (ready) begin
      if (bus.fetch_req) begin
        valid_q <= 1'b1;
        err_q   <= f_bad;
        out_q   <= f_bad ? '0 : mem[f_idx];
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.fetch_ready = ready;
  assign bus.instr_out   = out_q;
  assign bus.instr_valid = valid_q;
  assign bus.addr_err    = err_q;
  assign bus.busy        = !run;

endmodule

// File: tb/tb_instr_mem_param.sv
// Directed and randomized checks of instr_mem_param in word
// and byte addressing modes against a behavioural model.
module tb_instr_mem_param;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_mem_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  instr_mem_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  instr_mem_param #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BYTE_ADDR(0)
  ) u_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  instr_mem_param #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BYTE_ADDR(1)
  ) u_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mm [2][DEPTH];
  logic        ev [2];
  logic [31:0] eo [2];
  logic        ee [2];

  logic        stl [2];
  logic        rq  [2];
  logic [31:0] fa  [2];
  logic        le  [2];
  logic [31:0] la  [2];
  logic [31:0] ld  [2];

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus_a.fetch_req = 0; bus_a.fetch_addr = '0; bus_a.stall = 0;
    bus_a.load_en = 0; bus_a.load_addr = '0; bus_a.load_data = '0;
    bus_b.fetch_req = 0; bus_b.fetch_addr = '0; bus_b.stall = 0;
    bus_b.load_en = 0; bus_b.load_addr = '0; bus_b.load_data = '0;
  endtask

  task automatic fetch_a(logic [31:0] a);
    bus_a.fetch_req  = 1;
    bus_a.fetch_addr = a;
  endtask

  function automatic logic is_bad(int d, logic [31:0] a);
    if (d == 1) return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    return a >= 32'(DEPTH);
  endfunction

  function automatic int widx(int d, logic [31:0] a);
    return (d == 1) ? int'(a >> 2) : int'(a);
  endfunction

  function automatic logic [31:0] rand_addr(int d);
    int k;
    k = $urandom_range(0, 4);
    if (k == 0) return $urandom;
    if (k == 1) return (32'h1 << $urandom_range(7, 31)) | 32'($urandom_range(0, 31));
    return (d == 0) ? 32'($urandom_range(0, 35)) : 32'($urandom_range(0, 140));
  endfunction

  // Counts busy cycles from reset release; ready must stay low meanwhile.
  task automatic sweep(string tag);
    int  n;
    logic rdy_low;
    n = 0;
    rdy_low = 1'b1;
    while (bus_a.busy === 1'b1 && n < 40) begin
      if (bus_a.fetch_ready !== 1'b0 || bus_b.fetch_ready !== 1'b0)
        rdy_low = 1'b0;
      n++;
      tick();
    end
    chk32({tag, "_busy_cycles"}, 32'(n), 32'd32);
    chk1({tag, "_ready_low_in_init"}, rdy_low, 1'b1);
    chk1({tag, "_ready_after"}, bus_a.fetch_ready, 1'b1);
    chk1({tag, "_b_busy_after"}, bus_b.busy, 1'b0);
    chk1({tag, "_b_ready_after"}, bus_b.fetch_ready, 1'b1);
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick(); tick();
    chk1("rst_busy", bus_a.busy, 1'b1);
    chk1("rst_valid", bus_a.instr_valid, 1'b0);
    chk32("rst_out", bus_a.instr_out, 32'h0);
    chk1("rst_err", bus_a.addr_err, 1'b0);
    chk1("rst_ready", bus_a.fetch_ready, 1'b0);

    // abort the sweep part way, then a full sweep must follow
    rst = 0;
    fetch_a(1);
    tick(); tick(); tick(); tick(); tick();
    chk1("init_ignores_fetch", bus_a.instr_valid, 1'b0);
    rst = 1;
    #1;
    chk1("mid_init_rst_busy", bus_a.busy, 1'b1);
    idle();
    tick();
    rst = 0;
    sweep("sweep1");

    // load then fetch
    bus_a.load_en = 1; bus_a.load_addr = 1; bus_a.load_data = 32'h014B4020;
    tick();
    bus_a.load_addr = 33; bus_a.load_data = 32'hFFFFFFFF;
    tick();
    bus_a.load_en = 0;
    fetch_a(1);
    tick();
    chk32("fetch1_out", bus_a.instr_out, 32'h014B4020);
    chk1("fetch1_valid", bus_a.instr_valid, 1'b1);
    chk1("fetch1_err", bus_a.addr_err, 1'b0);
    fetch_a(2);
    tick();
    chk32("fetch2_out", bus_a.instr_out, 32'h0);
    fetch_a(1);
    tick();
    chk32("refetch1_out", bus_a.instr_out, 32'h014B4020);

    // stall hold
    bus_a.stall = 1;
    fetch_a(2);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("stall_ready", bus_a.fetch_ready, 1'b0);
      tick();
      chk32("stall_hold_out", bus_a.instr_out, 32'h014B4020);
      chk1("stall_hold_valid", bus_a.instr_valid, 1'b1);
    end
    bus_a.stall = 0;
    #1;
    chk1("unstall_ready", bus_a.fetch_ready, 1'b1);
    tick();
    chk32("unstall_out", bus_a.instr_out, 32'h0);
    chk1("unstall_valid", bus_a.instr_valid, 1'b1);
    bus_a.fetch_req = 0;
    tick();
    chk1("noreq_clears_valid", bus_a.instr_valid, 1'b0);

    // address errors
    fetch_a(32);
    tick();
    chk32("oor_out", bus_a.instr_out, 32'h0);
    chk1("oor_err", bus_a.addr_err, 1'b1);
    chk1("oor_valid", bus_a.instr_valid, 1'b1);
    fetch_a(32'h8000_0001);
    tick();
    chk1("oor_high_err", bus_a.addr_err, 1'b1);
    bus_a.fetch_req = 0;
    bus_b.load_en = 1; bus_b.load_addr = 4; bus_b.load_data = 32'hCAFEF00D;
    tick();
    bus_b.load_addr = 5; bus_b.load_data = 32'hDEADBEEF;
    tick();
    bus_b.load_en = 0;
    bus_b.fetch_req = 1; bus_b.fetch_addr = 6;
    tick();
    chk1("b_mis_err", bus_b.addr_err, 1'b1);
    chk32("b_mis_out", bus_b.instr_out, 32'h0);
    bus_b.fetch_addr = 4;
    tick();
    chk1("b_word1_err", bus_b.addr_err, 1'b0);
    chk32("b_word1_out", bus_b.instr_out, 32'hCAFEF00D);
    bus_b.fetch_req = 0;

    // same-index collision
    bus_a.fetch_req = 0;
    bus_a.load_en = 1; bus_a.load_addr = 5; bus_a.load_data = 32'hAAAA0000;
    tick();
    bus_a.load_data = 32'h12345678;
    fetch_a(5);
    tick();
    chk32("collide_old", bus_a.instr_out, 32'hAAAA0000);
    bus_a.load_en = 0;
    tick();
    chk32("collide_new", bus_a.instr_out, 32'h12345678);

    // randomized phase against the model
    idle();
    tick();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) mm[d][i] = '0;
      ev[d] = 0; eo[d] = '0; ee[d] = 0;
    end
    mm[0][1] = 32'h014B4020;
    mm[0][5] = 32'h12345678;
    mm[1][1] = 32'hCAFEF00D;
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        stl[d] = ($urandom_range(0, 3) == 0);
        rq[d]  = ($urandom_range(0, 2) != 0);
        fa[d]  = rand_addr(d);
        le[d]  = ($urandom_range(0, 1) == 1);
        la[d]  = rand_addr(d);
        ld[d]  = $urandom;
      end
      bus_a.stall = stl[0]; bus_a.fetch_req = rq[0]; bus_a.fetch_addr = fa[0];
      bus_a.load_en = le[0]; bus_a.load_addr = la[0]; bus_a.load_data = ld[0];
      bus_b.stall = stl[1]; bus_b.fetch_req = rq[1]; bus_b.fetch_addr = fa[1];
      bus_b.load_en = le[1]; bus_b.load_addr = la[1]; bus_b.load_data = ld[1];
      #1;
      for (int d = 0; d < 2; d++) begin
        logic rdy;
        rdy = !(ev[d] && stl[d]);
        chk1("rnd_ready", (d == 0) ? bus_a.fetch_ready : bus_b.fetch_ready, rdy);
        if (rdy) begin
          if (rq[d]) begin
            ee[d] = is_bad(d, fa[d]);
            eo[d] = ee[d] ? 32'h0 : mm[d][widx(d, fa[d])];
            ev[d] = 1;
          end else begin
            ev[d] = 0;
          end
        end
        if (le[d] && !is_bad(d, la[d])) mm[d][widx(d, la[d])] = ld[d];
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        chk1("rnd_valid", (d == 0) ? bus_a.instr_valid : bus_b.instr_valid, ev[d]);
        if (ev[d]) begin
          chk32("rnd_out", (d == 0) ? bus_a.instr_out : bus_b.instr_out, eo[d]);
          chk1("rnd_err", (d == 0) ? bus_a.addr_err : bus_b.addr_err, ee[d]);
        end
      end
    end

    // reset during a stalled valid output
    idle();
    tick();
    fetch_a(1);
    tick();
    chk1("pre_rst_valid", bus_a.instr_valid, 1'b1);
    bus_a.stall = 1;
    fetch_a(2);
    tick();
    #2;
    rst = 1;
    #1;
    chk1("async_rst_valid", bus_a.instr_valid, 1'b0);
    chk1("async_rst_busy", bus_a.busy, 1'b1);
    chk32("async_rst_out", bus_a.instr_out, 32'h0);
    chk1("async_rst_err", bus_a.addr_err, 1'b0);
    idle();
    tick();
    rst = 0;
    sweep("sweep2");
    for (int i = 0; i < DEPTH; i++) begin
      fetch_a(32'(i));
      tick();
      chk32("cleared_out", bus_a.instr_out, 32'h0);
      chk1("cleared_valid", bus_a.instr_valid, 1'b1);
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
